// File: rtl/bit_serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM encoding,
// handshake helper and the gate-level primitives.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry injected for A + ~B + 1.
  localparam logic SUB_CARRY = 1'b1;

  function automatic logic fire(
    input logic valid,
    input logic ready
  );
    return valid & ready;
  endfunction

  function automatic logic xor_gate(
    input logic x,
    input logic y
  );
    return x ^ y;
  endfunction

  function automatic logic and_gate(
    input logic x,
    input logic y
  );
    return x & y;
  endfunction

  function automatic logic or_gate(
    input logic x,
    input logic y
  );
    return x | y;
  endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder_cell.sv
// One-bit full adder built from the gate primitives.
// Ports: a, b, ci in; s (sum), co (carry) out.
module full_adder_cell
  import bit_serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = xor_gate(a, b);
  assign s  = xor_gate(p, ci);
  assign co = or_gate(and_gate(a, b), and_gate(ci, p));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock.
// Ports: in_valid/in_ready + a,b,sub,cin in; out_valid/out_ready + sum,cout,ovf out; busy.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_n;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             c_prev;
  logic             s_bit;
  logic             c_bit;
  logic             accept;
  logic             last;

  full_adder_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  assign accept = fire(in_valid, state == IDLE);
  assign last   = (cnt == CNT_LAST);
  assign sum    = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    cout      = 1'b0;
    ovf       = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        cout      = carry;
        // Overflow: carry into MSB differs from carry out.
        ovf       = c_prev ^ carry;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      c_prev <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? SUB_CARRY : cin;
            cnt   <= '0;
            sum_q <= '0;
          end
        end
        RUN: begin
          sum_q <= {s_bit, sum_q[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_bit;
          if (last) begin
            c_prev <= carry;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
Parametrised bit-serial adder/subtractor.
- Accepts two WIDTH-bit operands through a valid/ready handshake.
- Processes one bit per clock, LSB first, through a single full-adder cell built from the team's gate-level primitives.
- Returns sum, carry-out and signed overflow through a second valid/ready handshake.
- Sequential successor to the combinational gate library: trades latency for a single adder cell.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal values ≥ 2.
- CNT_W, $clog2(WIDTH+1), bit-counter width; a derived localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A − B, 0 = A + B + cin.
- cin  input  1  carry-in for add; ignored when sub=1.
- out_valid  output  1  result registers valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- busy  output  1  high while in RUN.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low, and forces the FSM to IDLE immediately.
- Reset values: in_ready=1 (combinational from IDLE), out_valid=0, busy=0, sum=0, cout=0, ovf=0. Internal operand shift registers, carry flop and counter all reset to 0.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - busy = (state==RUN).
  - out_valid = (state==DONE).
- IDLE, on in_valid && in_ready:
  - A_sh ← a.
  - B_sh ← sub ? ~b : b.
  - carry ← sub ? 1 : cin.
  - cnt ← 0, sum ← 0.
  - Go to RUN.
  - With in_valid low: hold.
- RUN, every cycle:
  - Full-adder cell computes s, c from A_sh[0], B_sh[0], carry.
  - sum ← {s, sum[WIDTH-1:1]}; A_sh and B_sh shift right by 1; carry ← c; cnt ← cnt+1.
  - When cnt==WIDTH-1, capture c_prev ← the current carry (carry into MSB) and go to DONE.
- DONE:
  - cout = carry; ovf = c_prev XOR carry.
  - sum, cout and ovf hold stable until out_valid && out_ready, then go to IDLE.
  - No new operation is accepted in DONE, even if out_ready and in_valid rise in the same cycle.
- Latency: operation accepted at edge E; out_valid is high from edge E+WIDTH. Throughput is one operation per WIDTH+2 cycles minimum.
- Input capture: in_valid in RUN or DONE is ignored and operands are not sampled. Inputs are sampled only at the accepting edge; later changes on a/b/sub/cin have no effect.
- Wrap-around: results are modulo 2^WIDTH, e.g. all-ones + 1 gives sum 0 with cout=1.
- Subtraction: computed as A + ~B + 1. Overflow uses the same rule as add.
- Reset mid-operation: any state returns to IDLE with all outputs at their reset values. The partial result is discarded and no out_valid pulse is produced.
- Invariants:
  - cnt never exceeds WIDTH-1.
  - out_valid and in_ready are never high together.

Decomposition:
- Shared package / include file holds:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Handshake-related constants.
- One sub-module, full_adder_cell, with ports (a, b, ci, s, co):
  - s = xor_gate(xor_gate(a, b), ci).
  - co = or_gate(and_gate(a, b), and_gate(ci, xor_gate(a, b))).
  - Instantiated once.
- Control FSM, counter and shift registers stay in the top module.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, sub=0, cin=0 → sum=0x7F, cout=0, ovf=0; out_valid rises exactly 8 cycles after acceptance.
- a=0x7F, b=0x01, add → sum=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0 (wrap-around).
- sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE → sum/cout/ovf stable, in_ready=0; in_valid pulses during RUN/DONE are not captured. Release out_ready → IDLE next cycle, in_ready=1.
- Assert rst_n=0 mid-RUN at cnt=3 → outputs immediately 0, out_valid never pulses. After release, a new 0x01+0x01 returns 0x02.
- WIDTH=16, a=0xFFFF, b=0x0001, cin=1 → sum=0x0001, cout=1, ovf=0, out_valid 16 cycles after acceptance.
